// File: rtl/bottle_pkg.sv
// Shared definitions for the bottling-lane sequencer.
//   state_e       : FSM states, also exported on the state port for display/debug
//   FC_*          : fault codes reported on fault_code
//   MAX_PILLS     : largest accepted pills-per-bottle setting
//   config_ok()   : operator-setting sanity check applied at every start
package bottle_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADVANCE = 3'd1,
    ST_FILL    = 3'd2,
    ST_SETTLE  = 3'd3,
    ST_RELEASE = 3'd4,
    ST_DONE    = 3'd5,
    ST_FAULT   = 3'd6
  } state_e;

  localparam logic [1:0] FC_NONE       = 2'b00;
  localparam logic [1:0] FC_BAD_CONFIG = 2'b01;
  localparam logic [1:0] FC_TIMEOUT    = 2'b10;
  localparam logic [1:0] FC_OVERFILL   = 2'b11;

  localparam int unsigned MAX_PILLS = 99;

  // A batch needs at least one pill per bottle (and no more than the display
  // can show) and at least one bottle.
  function automatic logic config_ok(input logic [6:0] pills,
                                     input logic [4:0] bottles);
    return (pills != 7'd0) && (pills <= 7'(MAX_PILLS)) && (bottles != 5'd0);
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Cycles-in-state counter with a terminal-count flag.
//   clk, rst : system clock, synchronous active-high reset
//   clear    : restart counting from zero on the next cycle
//   tc       : high during the LIMIT-th cycle after a clear, i.e. the last
//              cycle allowed before the owner must act
// The count saturates at LIMIT so a timer left running in an unrelated state
// never wraps and fires a spurious terminal count. LIMIT must be >= 1.
module cycle_timer #(
  parameter int unsigned LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tc
);

  localparam int unsigned W = $clog2(LIMIT + 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_q != W'(LIMIT)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Counting starts at 0 on the first cycle after a clear, so LIMIT-1 marks
  // the final cycle; the owner's transition then lands as the count would
  // reach LIMIT.
  assign tc = (count_q == W'(LIMIT - 1));

endmodule

// File: rtl/bottle_line_ctrl.sv
// Sequencer for one bottling lane: moves bottles under the chute, opens the
// pill feeder, counts pills into each bottle and reports stalls/overfills.
//   clk, rst              : system clock, synchronous active-high reset
//   start                 : level; rising edge in IDLE/DONE begins a batch
//   abort                 : level; forces IDLE from any state, highest priority
//   set_pills_per_bottle  : target pills per bottle (1..99), latched at start
//   set_total_bottles     : bottles per batch (1..31), latched at start
//   bottle_present        : bottle-under-chute sensor (synchronised)
//   pill_pulse            : one-cycle pulse per detected pill (synchronised)
//   conveyor_on, gate_open: actuator enables
//   pill_count            : pills in the current bottle
//   bottle_count          : bottles completed in this batch
//   bottle_done           : one-cycle pulse when a bottle reaches target
//   batch_done            : high in DONE
//   fault, fault_code     : high in FAULT; 01 bad config, 10 timeout, 11 overfill
//   state                 : current FSM state encoding
// All outputs come straight from flops; actuator flops are loaded from the
// next-state decode so they change on the first cycle of the new state.
module bottle_line_ctrl
  import bottle_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned SETTLE_CYCLES  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [6:0] set_pills_per_bottle,
  input  logic [4:0] set_total_bottles,
  input  logic       bottle_present,
  input  logic       pill_pulse,
  output logic       conveyor_on,
  output logic       gate_open,
  output logic [6:0] pill_count,
  output logic [4:0] bottle_count,
  output logic       bottle_done,
  output logic       batch_done,
  output logic       fault,
  output logic [1:0] fault_code,
  output logic [2:0] state
);

  state_e     state_q, state_d;

  logic       start_prev_q, start_prev_d;
  logic       start_edge_q, start_edge_d;

  logic [6:0] target_pills_q, target_pills_d;
  logic [4:0] target_bottles_q, target_bottles_d;
  logic [6:0] pill_q, pill_d;
  logic [4:0] bottle_q, bottle_d;
  logic [1:0] fault_code_q, fault_code_d;

  logic       conveyor_q, conveyor_d;
  logic       gate_q, gate_d;
  logic       bottle_done_q, bottle_done_d;
  logic       batch_done_q, batch_done_d;
  logic       fault_q, fault_d;

  logic [6:0] pill_inc;
  logic       tmo_restart;
  logic       tmo_clear;
  logic       tmo_tc;
  logic       settle_clear;
  logic       settle_tc;

  // Start edge detector. start_prev resets high so a start input that is
  // already asserted out of reset must drop and rise again to count.
  always_comb begin
    start_prev_d = start;
    start_edge_d = start & ~start_prev_q;
  end

  assign pill_inc = pill_q + 7'd1;

  // Next-state and datapath
  always_comb begin
    state_d          = state_q;
    target_pills_d   = target_pills_q;
    target_bottles_d = target_bottles_q;
    pill_d           = pill_q;
    bottle_d         = bottle_q;
    fault_code_d     = fault_code_q;
    bottle_done_d    = 1'b0;
    tmo_restart      = 1'b0;

    if (abort) begin
      // Counters deliberately hold so the operator can still read them.
      state_d      = ST_IDLE;
      fault_code_d = FC_NONE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_edge_q) begin
            target_pills_d   = set_pills_per_bottle;
            target_bottles_d = set_total_bottles;
            if (!config_ok(set_pills_per_bottle, set_total_bottles)) begin
              state_d      = ST_FAULT;
              fault_code_d = FC_BAD_CONFIG;
            end else begin
              state_d  = ST_ADVANCE;
              pill_d   = 7'd0;
              bottle_d = 5'd0;
            end
          end
        end

        ST_ADVANCE: begin
          if (bottle_present) begin
            state_d = ST_FILL;
          end else if (tmo_tc) begin
            state_d      = ST_FAULT;
            fault_code_d = FC_TIMEOUT;
          end
        end

        ST_FILL: begin
          // A pill arriving on the timeout's last cycle is progress, so it
          // takes precedence and restarts the inter-pill timer.
          if (pill_pulse) begin
            pill_d      = pill_inc;
            tmo_restart = 1'b1;
            if (pill_inc == target_pills_q) begin
              state_d       = ST_SETTLE;
              bottle_done_d = 1'b1;
              bottle_d      = bottle_q + 5'd1;
            end
          end else if (tmo_tc) begin
            state_d      = ST_FAULT;
            fault_code_d = FC_TIMEOUT;
          end
        end

        ST_SETTLE: begin
          // Gate is shut, so any pill seen now is an over-dispense.
          if (pill_pulse) begin
            state_d      = ST_FAULT;
            fault_code_d = FC_OVERFILL;
          end else if (settle_tc) begin
            state_d = ST_RELEASE;
          end
        end

        ST_RELEASE: begin
          if (!bottle_present) begin
            if (bottle_q == target_bottles_q) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_ADVANCE;
              pill_d  = 7'd0;
            end
          end else if (tmo_tc) begin
            state_d      = ST_FAULT;
            fault_code_d = FC_TIMEOUT;
          end
        end

        ST_FAULT: begin
          // Latched until abort or reset.
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Registered outputs decoded from the state being entered.
  always_comb begin
    conveyor_d   = (state_d == ST_ADVANCE) || (state_d == ST_RELEASE);
    gate_d       = (state_d == ST_FILL);
    batch_done_d = (state_d == ST_DONE);
    fault_d      = (state_d == ST_FAULT);
  end

  // Both timers restart on every state entry; the timeout timer also
  // restarts on each accepted pill so it measures the gap between pills.
  always_comb begin
    settle_clear = (state_d != state_q);
    tmo_clear    = (state_d != state_q) || tmo_restart;
  end

  cycle_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (tmo_clear),
    .tc    (tmo_tc)
  );

  cycle_timer #(
    .LIMIT (SETTLE_CYCLES)
  ) u_settle_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (settle_clear),
    .tc    (settle_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      start_prev_q     <= 1'b1;
      start_edge_q     <= 1'b0;
      target_pills_q   <= 7'd0;
      target_bottles_q <= 5'd0;
      pill_q           <= 7'd0;
      bottle_q         <= 5'd0;
      fault_code_q     <= FC_NONE;
      conveyor_q       <= 1'b0;
      gate_q           <= 1'b0;
      bottle_done_q    <= 1'b0;
      batch_done_q     <= 1'b0;
      fault_q          <= 1'b0;
    end else begin
      state_q          <= state_d;
      start_prev_q     <= start_prev_d;
      start_edge_q     <= start_edge_d;
      target_pills_q   <= target_pills_d;
      target_bottles_q <= target_bottles_d;
      pill_q           <= pill_d;
      bottle_q         <= bottle_d;
      fault_code_q     <= fault_code_d;
      conveyor_q       <= conveyor_d;
      gate_q           <= gate_d;
      bottle_done_q    <= bottle_done_d;
      batch_done_q     <= batch_done_d;
      fault_q          <= fault_d;
    end
  end

  assign conveyor_on  = conveyor_q;
  assign gate_open    = gate_q;
  assign pill_count   = pill_q;
  assign bottle_count = bottle_q;
  assign bottle_done  = bottle_done_q;
  assign batch_done   = batch_done_q;
  assign fault        = fault_q;
  assign fault_code   = fault_code_q;
  assign state        = state_q;

endmodule

// File: tb/tb_bottle_line_ctrl.sv
// Self-checking bench for bottle_line_ctrl. Expected values are derived from
// the batch configuration (pill/bottle targets, timeout and settle lengths)
// rather than from the controller's internal state.
module tb_bottle_line_ctrl;

  localparam int TMO    = 40;
  localparam int SETTLE = 4;

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic [6:0] set_pills_per_bottle;
  logic [4:0] set_total_bottles;
  logic       bottle_present;
  logic       pill_pulse;
  logic       conveyor_on;
  logic       gate_open;
  logic [6:0] pill_count;
  logic [4:0] bottle_count;
  logic       bottle_done;
  logic       batch_done;
  logic       fault;
  logic [1:0] fault_code;
  logic [2:0] state;

  int n_assert;
  int n_fail;
  int done_pulses;
  int conv_seen;
  int gate_seen;

  bottle_line_ctrl #(
    .TIMEOUT_CYCLES (TMO),
    .SETTLE_CYCLES  (SETTLE)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .start                (start),
    .abort                (abort),
    .set_pills_per_bottle (set_pills_per_bottle),
    .set_total_bottles    (set_total_bottles),
    .bottle_present       (bottle_present),
    .pill_pulse           (pill_pulse),
    .conveyor_on          (conveyor_on),
    .gate_open            (gate_open),
    .pill_count           (pill_count),
    .bottle_count         (bottle_count),
    .bottle_done          (bottle_done),
    .batch_done           (batch_done),
    .fault                (fault),
    .fault_code           (fault_code),
    .state                (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (bottle_done === 1'b1) done_pulses++;
    if (conveyor_on === 1'b1) conv_seen = 1;
    if (gate_open === 1'b1) gate_seen = 1;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_fault", 32'(fault), 0);
    check("abort_code", 32'(fault_code), 0);
    check("abort_act", 32'(conveyor_on | gate_open), 0);
  endtask

  // Rising start edge; conveyor must come on exactly two cycles later with
  // both counters cleared.
  task automatic start_batch(input int p, input int b);
    set_pills_per_bottle = 7'(p);
    set_total_bottles    = 5'(b);
    bottle_present       = 1'b0;
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    check("start_lat1", 32'(conveyor_on), 0);
    tick();
    start = 1'b0;
    check("start_conv", 32'(conveyor_on), 1);
    check("start_pills", 32'(pill_count), 0);
    check("start_bottles", 32'(bottle_count), 0);
    check("start_fault", 32'(fault), 0);
  endtask

  // Fill a whole batch with random sensor timing and noise; expected values
  // come from the batch targets alone.
  task automatic fill_batch(input int pills, input int bottles);
    done_pulses = 0;
    for (int b = 0; b < bottles; b++) begin
      // Stray pills and config changes while waiting for a bottle.
      repeat ($urandom_range(0, 4)) begin
        pill_pulse           = 1'($urandom_range(0, 1));
        set_pills_per_bottle = 7'($urandom);
        set_total_bottles    = 5'($urandom);
        tick();
      end
      pill_pulse = 1'b0;
      check("adv_conv", 32'(conveyor_on), 1);
      check("adv_pills", 32'(pill_count), 0);
      bottle_present = 1'b1;
      tick();
      check("fill_gate", 32'(gate_open), 1);
      check("fill_conv", 32'(conveyor_on), 0);
      for (int p = 1; p <= pills; p++) begin
        repeat ($urandom_range(0, 3)) tick();
        pill_pulse = 1'b1;
        tick();
        pill_pulse = 1'b0;
        check("pill_count", 32'(pill_count), 32'(p));
        if (p == pills) begin
          check("target_gate", 32'(gate_open), 0);
          check("target_done", 32'(bottle_done), 1);
          check("target_bottles", 32'(bottle_count), 32'(b + 1));
        end else begin
          check("mid_gate", 32'(gate_open), 1);
          check("mid_done", 32'(bottle_done), 0);
        end
      end
      repeat (SETTLE - 1) begin
        tick();
        check("settle_act", 32'(conveyor_on | gate_open), 0);
      end
      tick();
      check("release_conv", 32'(conveyor_on), 1);
      repeat ($urandom_range(0, 3)) begin
        pill_pulse = 1'($urandom_range(0, 1));
        tick();
      end
      pill_pulse = 1'b0;
      check("release_pills", 32'(pill_count), 32'(pills));
      bottle_present = 1'b0;
      tick();
      if (b == bottles - 1) begin
        check("batch_done", 32'(batch_done), 1);
        check("done_conv", 32'(conveyor_on), 0);
        check("done_bottles", 32'(bottle_count), 32'(bottles));
      end else begin
        check("next_conv", 32'(conveyor_on), 1);
        check("next_pills", 32'(pill_count), 0);
        check("next_batch_done", 32'(batch_done), 0);
      end
    end
    check("done_pulses", 32'(done_pulses), 32'(bottles));
  endtask

  initial begin
    int p;
    int b;
    n_assert = 0;
    n_fail = 0;
    done_pulses = 0;
    conv_seen = 0;
    gate_seen = 0;
    rst = 1'b1;
    start = 1'b1;
    abort = 1'b0;
    set_pills_per_bottle = 7'd3;
    set_total_bottles = 5'd2;
    bottle_present = 1'b0;
    pill_pulse = 1'b0;

    // Reset with start held high
    repeat (3) tick();
    check("rst_conv", 32'(conveyor_on), 0);
    check("rst_gate", 32'(gate_open), 0);
    check("rst_pills", 32'(pill_count), 0);
    check("rst_bottles", 32'(bottle_count), 0);
    check("rst_bdone", 32'(bottle_done), 0);
    check("rst_batch", 32'(batch_done), 0);
    check("rst_fault", 32'(fault), 0);
    check("rst_code", 32'(fault_code), 0);
    check("rst_state", 32'(state), 0);
    rst = 1'b0;
    repeat (4) tick();
    check("held_start_conv", 32'(conveyor_on), 0);
    check("held_start_fault", 32'(fault), 0);

    // 3 pills x 2 bottles
    start_batch(3, 2);
    fill_batch(3, 2);

    // Zero-pill config: fault 01 within two cycles, actuators untouched
    conv_seen = 0;
    gate_seen = 0;
    set_pills_per_bottle = 7'd0;
    set_total_bottles = 5'd2;
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    check("badcfg_fault", 32'(fault), 1);
    check("badcfg_code", 32'(fault_code), 1);
    repeat (3) tick();
    check("badcfg_conv_seen", 32'(conv_seen), 0);
    check("badcfg_gate_seen", 32'(gate_seen), 0);
    do_abort();

    // ADVANCE stall: fault 10 exactly TMO cycles after entry
    start_batch(2, 1);
    repeat (TMO - 1) tick();
    check("adv_tmo_conv_pre", 32'(conveyor_on), 1);
    check("adv_tmo_fault_pre", 32'(fault), 0);
    tick();
    check("adv_tmo_fault", 32'(fault), 1);
    check("adv_tmo_code", 32'(fault_code), 2);
    check("adv_tmo_conv", 32'(conveyor_on), 0);
    do_abort();

    // FILL: pill on the last allowed cycle wins, then a real stall times out
    start_batch(4, 1);
    bottle_present = 1'b1;
    tick();
    repeat (TMO - 1) tick();
    pill_pulse = 1'b1;
    tick();
    pill_pulse = 1'b0;
    check("tc_pill_fault", 32'(fault), 0);
    check("tc_pill_count", 32'(pill_count), 1);
    repeat (TMO - 1) tick();
    check("fill_tmo_gate_pre", 32'(gate_open), 1);
    tick();
    check("fill_tmo_fault", 32'(fault), 1);
    check("fill_tmo_code", 32'(fault_code), 2);
    check("fill_tmo_gate", 32'(gate_open), 0);
    do_abort();
    check("abort_hold_pills", 32'(pill_count), 1);
    bottle_present = 1'b0;

    // Overfill: extra pill two cycles into SETTLE
    start_batch(3, 1);
    bottle_present = 1'b1;
    tick();
    repeat (3) begin
      pill_pulse = 1'b1;
      tick();
      pill_pulse = 1'b0;
    end
    tick();
    pill_pulse = 1'b1;
    tick();
    pill_pulse = 1'b0;
    check("ovf_fault", 32'(fault), 1);
    check("ovf_code", 32'(fault_code), 3);
    check("ovf_pills", 32'(pill_count), 3);
    repeat (3) tick();
    check("ovf_hold_fault", 32'(fault), 1);
    check("ovf_hold_act", 32'(conveyor_on | gate_open), 0);
    do_abort();
    bottle_present = 1'b0;

    // Abort mid-FILL at 5 pills, with a coincident pill that must not count
    start_batch(8, 1);
    bottle_present = 1'b1;
    tick();
    repeat (5) begin
      pill_pulse = 1'b1;
      tick();
      pill_pulse = 1'b0;
    end
    check("pre_abort_pills", 32'(pill_count), 5);
    pill_pulse = 1'b1;
    abort = 1'b1;
    tick();
    pill_pulse = 1'b0;
    abort = 1'b0;
    bottle_present = 1'b0;
    check("mid_abort_gate", 32'(gate_open), 0);
    check("mid_abort_conv", 32'(conveyor_on), 0);
    check("mid_abort_pills", 32'(pill_count), 5);
    tick();
    check("idle_hold_pills", 32'(pill_count), 5);

    // Config raised to 10 after start: batch still uses 5
    start_batch(5, 2);
    set_pills_per_bottle = 7'd10;
    fill_batch(5, 2);

    // Randomised batches started from DONE
    repeat (4) begin
      p = $urandom_range(1, 6);
      b = $urandom_range(1, 3);
      start_batch(p, b);
      fill_batch(p, b);
    end

    // Randomised invalid configurations
    repeat (4) begin
      case ($urandom_range(0, 2))
        0: begin
          set_pills_per_bottle = 7'd0;
          set_total_bottles = 5'($urandom_range(1, 31));
        end
        1: begin
          set_pills_per_bottle = 7'($urandom_range(100, 127));
          set_total_bottles = 5'($urandom_range(1, 31));
        end
        default: begin
          set_pills_per_bottle = 7'($urandom_range(1, 99));
          set_total_bottles = 5'd0;
        end
      endcase
      start = 1'b0;
      tick();
      start = 1'b1;
      tick();
      tick();
      start = 1'b0;
      check("rand_badcfg_fault", 32'(fault), 1);
      check("rand_badcfg_code", 32'(fault_code), 1);
      do_abort();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
